// File: rtl/bcd_pkg.sv
// Shared BCD digit type, digit limits and load-time sanitising helper.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX  = 4'd9;
    localparam bcd_digit_t BCD_ZERO = 4'd0;

    function automatic bcd_digit_t bcd_sanitize(input bcd_digit_t digit);
        return (digit > BCD_MAX) ? BCD_ZERO : digit;
    endfunction

endpackage

// File: rtl/bcd_digit_step.sv
// One BCD digit of the step chain: applies +1/-1 when step_in_i is set and
// reports the carry/borrow to the next digit.
module bcd_digit_step
    import bcd_pkg::*;
(
    input  bcd_digit_t digit_i,
    input  logic       up_i,
    input  logic       step_in_i,
    output bcd_digit_t digit_o,
    output logic       step_out_o
);

    always_comb begin
        digit_o    = digit_i;
        step_out_o = 1'b0;
        if (step_in_i) begin
            if (up_i) begin
                if (digit_i >= BCD_MAX) begin
                    digit_o    = BCD_ZERO;
                    step_out_o = 1'b1;
                end else begin
                    digit_o = digit_i + 4'd1;
                end
            end else begin
                if (digit_i == BCD_ZERO) begin
                    digit_o    = BCD_MAX;
                    step_out_o = 1'b1;
                end else begin
                    digit_o = digit_i - 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/bcd_counter_multi.sv
// N-digit BCD up/down counter with prescaler, step position select, load and
// sticky flags. Define BCD_COUNTER_SATURATE_EN to saturate instead of wrapping.
module bcd_counter_multi #(
    parameter int NUM_DIGITS = 4,
    parameter int TICK_DIV   = 25000000,
    parameter int SEL_W      = 3
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic                    Enable,
    input  logic                    Up,
    input  logic [SEL_W-1:0]        Digit_sel,
    input  logic                    Load,
    input  logic [4*NUM_DIGITS-1:0] Load_value,
    output logic [4*NUM_DIGITS-1:0] BCD,
    output logic                    Tick,
    output logic                    Overflow,
    output logic                    Underflow
);

    import bcd_pkg::*;

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] PRESC_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] presc_q, presc_d;
    logic             tick_int;
    logic             tick_q;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             step_en;
    logic [NUM_DIGITS:0] carry;

    bcd_digit_t [NUM_DIGITS-1:0] digits_q, digits_d, stepped, loaded;

    assign tick_int = (presc_q == PRESC_LAST);
    assign step_en  = tick_int & Enable & ~Load;
    assign carry[0] = 1'b0;

    // The step enters at the selected digit; every other digit only sees the
    // ripple from below, so an out-of-range Digit_sel leaves the chain idle.
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        logic sel_hit;
        assign sel_hit   = step_en && (Digit_sel == SEL_W'(i));
        assign loaded[i] = bcd_sanitize(Load_value[4*i +: 4]);

        bcd_digit_step u_step (
            .digit_i    (digits_q[i]),
            .up_i       (Up),
            .step_in_i  (sel_hit | carry[i]),
            .digit_o    (stepped[i]),
            .step_out_o (carry[i+1])
        );
    end

    always_comb begin
        presc_d  = tick_int ? '0 : presc_q + CNT_W'(1);
        digits_d = digits_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        if (Load) begin
            digits_d = loaded;
            ovf_d    = 1'b0;
            unf_d    = 1'b0;
        end else begin
            digits_d = stepped;
            if (carry[NUM_DIGITS]) begin
                if (Up) ovf_d = 1'b1;
                else    unf_d = 1'b1;
`ifdef BCD_COUNTER_SATURATE_EN
                digits_d = Up ? {NUM_DIGITS{BCD_MAX}} : {NUM_DIGITS{BCD_ZERO}};
`endif
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            presc_q  <= '0;
            tick_q   <= 1'b0;
            digits_q <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            presc_q  <= presc_d;
            tick_q   <= tick_int;
            digits_q <= digits_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    assign BCD       = digits_q;
    assign Tick      = tick_q;
    assign Overflow  = ovf_q;
    assign Underflow = unf_q;

endmodule
